// File: rtl/latency_mem_server_pkg.sv
// Shared types and helpers for the latency memory server and its response FIFO.
package latency_mem_server_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Merge the strobed bytes of new_word over old_word.
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/latency_mem_server_rsp_fifo.sv
// In-order circular-buffer FIFO with wrap bits for full/empty detection.
// Latency: a push is visible at the head on the next cycle (no bypass).
// Backpressure: pop_rdy low holds the head; push into a full FIFO is dropped.
module rsp_fifo #(
  parameter int p_depth      = 4,
  parameter int p_entry_bits = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_val,
  input  logic [p_entry_bits-1:0] push_data,
  input  logic                    pop_rdy,
  output logic                    pop_val,
  output logic [p_entry_bits-1:0] pop_data
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(p_depth - 1);

  logic [p_entry_bits-1:0] buf_q [p_depth];
  logic [PTR_W-1:0]        head_idx;
  logic [PTR_W-1:0]        tail_idx;
  logic                    head_wrap;
  logic                    tail_wrap;
  logic                    empty;
  logic                    full;
  logic                    push_fire;
  logic                    pop_fire;

  assign empty     = (head_idx == tail_idx) && (head_wrap == tail_wrap);
  assign full      = (head_idx == tail_idx) && (head_wrap != tail_wrap);
  assign push_fire = push_val && !full;
  assign pop_fire  = pop_rdy && !empty;

  assign pop_val  = !empty;
  assign pop_data = buf_q[head_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_idx  <= '0;
      tail_idx  <= '0;
      head_wrap <= 1'b0;
      tail_wrap <= 1'b0;
    end else begin
      if (push_fire) begin
        if (tail_idx == LAST_IDX) begin
          tail_idx  <= '0;
          tail_wrap <= ~tail_wrap;
        end else begin
          tail_idx <= tail_idx + PTR_W'(1);
        end
      end
      if (pop_fire) begin
        if (head_idx == LAST_IDX) begin
          head_idx  <= '0;
          head_wrap <= ~head_wrap;
        end else begin
          head_idx <= head_idx + PTR_W'(1);
        end
      end
    end
  end

  // Payload storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push_fire) buf_q[tail_idx] <= push_data;
  end

`ifndef SYNTHESIS
  function automatic int occupancy();
    if (head_wrap == tail_wrap) return int'(tail_idx) - int'(head_idx);
    return p_depth - int'(head_idx) + int'(tail_idx);
  endfunction

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(push_val && full));
`endif

endmodule

// File: rtl/latency_mem_server.sv
// Word-addressed memory server: accesses the array at request fire, responds in order.
// Latency: response valid p_latency cycles after fire; pipe never stalls.
// Backpressure: credits cover pipe + FIFO, so req_rdy drops once p_rsp_depth are outstanding.
module latency_mem_server
  import latency_mem_server_pkg::*;
#(
  parameter int p_opaq_bits = 8,
  parameter int p_mem_words = 256,
  parameter int p_latency   = 3,
  parameter int p_rsp_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_strb,
  output logic                   rsp_val,
  input  logic                   rsp_rdy,
  output logic                   rsp_op,
  output logic [p_opaq_bits-1:0] rsp_opaque,
  output logic [31:0]            rsp_data
);

  localparam int IDX_W = $clog2(p_mem_words);
  localparam int CRD_W = $clog2(p_rsp_depth + 1);

  typedef struct packed {
    mem_op_e                op;
    logic [p_opaq_bits-1:0] opaque;
    logic [DATA_W-1:0]      data;
  } rsp_ent_t;

  localparam int ENT_W = $bits(rsp_ent_t);

  logic [DATA_W-1:0] mem [p_mem_words];
  logic [IDX_W-1:0]  req_idx;
  logic              req_fire;
  logic              rsp_fire;
  logic [CRD_W-1:0]  credits;
  rsp_ent_t          s0_ent;
  logic              push_vld;
  rsp_ent_t          push_ent;
  logic              fifo_vld;
  logic [ENT_W-1:0]  fifo_dat;
  rsp_ent_t          head_ent;
  logic              unused_addr_bits;

  assign req_idx          = req_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  assign req_rdy  = (credits != '0) & rst;
  assign req_fire = req_val & req_rdy;
  assign rsp_fire = rsp_val & rsp_rdy;

  // Reads sample the array before this edge's write lands.
  always_comb begin
    s0_ent        = '0;
    s0_ent.op     = mem_op_e'(req_op);
    s0_ent.opaque = req_opaque;
    s0_ent.data   = (req_op == MEM_WR) ? '0 : mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (req_fire && (req_op == MEM_WR)) begin
      mem[req_idx] <= apply_strb(mem[req_idx], req_data, req_strb);
    end
  end

  // The fire cycle counts as the first stage, so p_latency-1 registers follow it.
  if (p_latency == 1) begin : g_lat1
    assign push_vld = req_fire;
    assign push_ent = s0_ent;
  end else begin : g_pipe
    logic     stg_vld [p_latency-1];
    rsp_ent_t stg_ent [p_latency-1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < p_latency - 1; i++) stg_vld[i] <= 1'b0;
      end else begin
        stg_vld[0] <= req_fire;
        for (int i = 1; i < p_latency - 1; i++) stg_vld[i] <= stg_vld[i-1];
      end
      stg_ent[0] <= s0_ent;
      for (int i = 1; i < p_latency - 1; i++) stg_ent[i] <= stg_ent[i-1];
    end

    assign push_vld = stg_vld[p_latency-2];
    assign push_ent = stg_ent[p_latency-2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits <= CRD_W'(p_rsp_depth);
    end else if (req_fire && !rsp_fire) begin
      credits <= credits - CRD_W'(1);
    end else if (!req_fire && rsp_fire) begin
      credits <= credits + CRD_W'(1);
    end
  end

  rsp_fifo #(
    .p_depth      (p_rsp_depth),
    .p_entry_bits (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_val  (push_vld),
    .push_data (push_ent),
    .pop_rdy   (rsp_rdy & rst),
    .pop_val   (fifo_vld),
    .pop_data  (fifo_dat)
  );

  // The FIFO clears on the reset edge, so mask its head during the reset cycle itself.
  assign head_ent   = rsp_ent_t'(fifo_dat);
  assign rsp_val    = fifo_vld & rst;
  assign rsp_op     = rsp_val & (head_ent.op == MEM_WR);
  assign rsp_opaque = rsp_val ? head_ent.opaque : '0;
  assign rsp_data   = rsp_val ? head_ent.data : '0;

`ifndef SYNTHESIS
  task automatic backdoor_load(input int unsigned idx, input logic [DATA_W-1:0] word);
    logic [31:0] idx_v;
    idx_v = idx;
    mem[idx_v[IDX_W-1:0]] <= word;
  endtask

  function automatic string trace();
    string s;
    if (req_fire) s = $sformatf("%s %08h:%0h", req_op ? "wr" : "rd", req_addr, req_opaque);
    else          s = "                  ";
    return $sformatf("%s | fifo %0d", s, u_fifo.occupancy());
  endfunction

  a_credit_bound : assert property (@(posedge clk) disable iff (!rst)
                                    credits <= CRD_W'(p_rsp_depth));
`endif

endmodule

// File: tb/tb_latency_mem_server.sv
// Randomized bench for latency_mem_server against a queue-based reference model.
module tb_latency_mem_server;

  localparam int L = 3;
  localparam int D = 4;
  localparam int W = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic        rsp_val;
  logic        rsp_rdy;
  logic        rsp_op;
  logic [7:0]  rsp_opaque;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  latency_mem_server #(
    .p_opaq_bits (8),
    .p_mem_words (W),
    .p_latency   (L),
    .p_rsp_depth (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_op     (req_op),
    .req_opaque (req_opaque),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_strb   (req_strb),
    .rsp_val    (rsp_val),
    .rsp_rdy    (rsp_rdy),
    .rsp_op     (rsp_op),
    .rsp_opaque (rsp_opaque),
    .rsp_data   (rsp_data)
  );

  typedef struct {
    logic        op;
    logic [7:0]  opq;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [W];
  logic [31:0] seen_data [256];
  int          seen_cyc [256];
  int          fire_cyc [256];
  int          cyc, n_cmp, n_err, dut_acc, dut_pop, base, pbase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, check against the model, then advance the model.
  task automatic tick();
    logic        er, ev;
    int          idx;
    logic [31:0] mask;
    exp_t        e;
    @(negedge clk);
    er = rst && (q.size() < D);
    ev = rst && (q.size() != 0) && (q[0].due <= cyc);
    chk("req_rdy", 64'(req_rdy), 64'(er));
    chk("rsp_val", 64'(rsp_val), 64'(ev));
    if (ev) begin
      chk("rsp_op", 64'(rsp_op), 64'(q[0].op));
      chk("rsp_opaque", 64'(rsp_opaque), 64'(q[0].opq));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
    end else begin
      chk("idle_data", 64'(rsp_data), 64'd0);
    end
    if (req_val && req_rdy) dut_acc++;
    if (rsp_val && rsp_rdy) begin
      dut_pop++;
      seen_data[rsp_opaque] = rsp_data;
      seen_cyc[rsp_opaque]  = cyc;
    end
    if (!rst) begin
      q.delete();
    end else begin
      if (ev && rsp_rdy) void'(q.pop_front());
      if (req_val && er) begin
        idx   = int'((req_addr % 32'(4 * W)) / 32'd4);
        e.op  = req_op;
        e.opq = req_opaque;
        e.data = req_op ? 32'd0 : mmem[idx];
        e.due = cyc + L;
        q.push_back(e);
        fire_cyc[req_opaque] = cyc;
        if (req_op) begin
          mask = {{8{req_strb[3]}}, {8{req_strb[2]}}, {8{req_strb[1]}}, {8{req_strb[0]}}};
          mmem[idx] = (mmem[idx] & ~mask) | (req_data & mask);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put(input logic op, input logic [7:0] opq, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    req_val = 1'b1; req_op = op; req_opaque = opq;
    req_addr = a; req_data = d; req_strb = s;
  endtask

  task automatic idle(input int n, input logic rr);
    req_val = 1'b0;
    rsp_rdy = rr;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0; req_val = 1'b0; req_op = 1'b0; req_opaque = '0;
    req_addr = '0; req_data = '0; req_strb = '0; rsp_rdy = 1'b1;
    cyc = 0; n_cmp = 0; n_err = 0; dut_acc = 0; dut_pop = 0;
    for (int i = 0; i < 256; i++) begin
      seen_data[i] = '0; seen_cyc[i] = 0; fire_cyc[i] = 0;
    end
    for (int i = 0; i < W; i++) mmem[i] = $urandom();
    mmem[0] = 32'h0BADF00D;
    mmem[4] = 32'hDEADBEEF;
    mmem[8] = 32'hAABBCCDD;
    for (int i = 0; i < W; i++) dut.backdoor_load(i, mmem[i]);
    @(posedge clk);
    #1;

    // Reset state
    repeat (2) tick();
    rst = 1'b1;

    // Plain read with fixed latency
    put(1'b0, 8'h05, 32'h10, 32'h0, 4'h0); tick();
    idle(5, 1'b1);
    chk("tp1_data", 64'(seen_data[5]), 64'h0000_0000_DEAD_BEEF);
    chk("tp1_latency", 64'(seen_cyc[5] - fire_cyc[5]), 64'd3);

    // Strobed write followed by read-after-write
    put(1'b1, 8'h06, 32'h20, 32'h11223344, 4'b0101); tick();
    put(1'b0, 8'h07, 32'h20, 32'h0, 4'h0); tick();
    idle(5, 1'b1);
    chk("tp2_rd_merge", 64'(seen_data[7]), 64'h0000_0000_AA22_CC44);
    chk("tp2_wr_data", 64'(seen_data[6]), 64'd0);

    // Backpressure: only D accepted, then in-order drain
    base = dut_acc;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put(1'b0, 8'(dut_acc - base), 32'(i * 4), 32'h0, 4'h0);
      tick();
    end
    chk("tp3_accepted", 64'(dut_acc - base), 64'd4);
    idle(8, 1'b1);

    // Full-rate streaming
    base = dut_acc; pbase = dut_pop;
    for (int i = 0; i < 20; i++) begin
      put(1'b0, 8'(100 + i), 32'(i * 4), 32'h0, 4'h0);
      tick();
    end
    chk("tp4_accepted", 64'(dut_acc - base), 64'd20);
    idle(6, 1'b1);
    chk("tp4_popped", 64'(dut_pop - pbase), 64'd20);

    // Mid-operation reset drops in-flight responses and restores credits
    put(1'b0, 8'd50, 32'h4, 32'h0, 4'h0); tick();
    put(1'b0, 8'd51, 32'h8, 32'h0, 4'h0); tick();
    rst = 1'b0;
    put(1'b0, 8'd52, 32'hC, 32'h0, 4'h0); tick();
    rst = 1'b1;
    base = dut_pop;
    idle(6, 1'b1);
    chk("tp5_no_rsp", 64'(dut_pop - base), 64'd0);
    base = dut_acc;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1'b0, 8'(60 + i), 32'(i * 4), 32'h0, 4'h0);
      tick();
    end
    chk("tp5_credits", 64'(dut_acc - base), 64'd4);
    idle(8, 1'b1);

    // Address aliasing
    put(1'b0, 8'd200, 32'h403, 32'h0, 4'h0); tick();
    idle(5, 1'b1);
    chk("tp6_alias", 64'(seen_data[200]), 64'h0000_0000_0BAD_F00D);

    // Randomized traffic with hazards, stalls and occasional resets
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      a = $urandom();
      a[9:2] = 8'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) != 0);
      put(1'($urandom_range(0, 1)), 8'($urandom()), a, $urandom(), 4'($urandom()));
      req_val = ($urandom_range(0, 3) != 0);
      rsp_rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b1;
    idle(10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
